// File: rtl/silencer_settings_fetch.sv
`default_nettype none
// ============================================================================
// Module   : silencer_settings_fetch
// Brief    : Fetches five silencer configuration words from the control BRAM
//            on host request, validates them and publishes them as a
//            silencer_settings_t record with a one-cycle UPDATE strobe.
// Revision : 1.0 - initial release
// ============================================================================

package silencer_settings_pkg;
   typedef struct packed {
      logic        UPDATE;
      logic        MODE;
      logic [15:0] UPDATE_RATE_INTENSITY;
      logic [15:0] UPDATE_RATE_PHASE;
      logic [15:0] COMPLETION_STEPS_INTENSITY;
      logic [15:0] COMPLETION_STEPS_PHASE;
   } silencer_settings_t;
endpackage

module silencer_settings_fetch
   import silencer_settings_pkg::*;
#(
   parameter logic [7:0] BASE_ADDR  = 8'h40,
   parameter int         RD_LATENCY = 2
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               REQ,
   output logic               BRAM_EN,
   output logic [7:0]         BRAM_ADDR,
   input  logic [15:0]        BRAM_DOUT,
   output silencer_settings_t SILENCER_SETTINGS,
   output logic               BUSY,
   output logic               ERR
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] FETCH  = 2'd1;
   localparam logic [1:0] CHECK  = 2'd2;
   localparam logic [1:0] COMMIT = 2'd3;

   localparam logic [2:0] LAST_WORD = 3'd4;

   logic [1:0]            state;
   logic                  pending;
   logic                  rd_en;
   logic [2:0]            rd_idx;

   // In-flight read tracking: one valid bit and word index per latency stage
   logic [RD_LATENCY-1:0] pipe_vld;
   logic [2:0]            pipe_idx [RD_LATENCY];
   logic                  capture;
   logic [2:0]            cap_idx;
   logic                  last_capture;

   logic                  sh_mode;
   logic [15:0]           sh_rate_int;
   logic [15:0]           sh_rate_phs;
   logic [15:0]           sh_steps_int;
   logic [15:0]           sh_steps_phs;
   logic                  cfg_ok;

   silencer_settings_t    settings;
   logic                  err_pulse;

   assign capture      = pipe_vld[RD_LATENCY-1];
   assign cap_idx      = pipe_idx[RD_LATENCY-1];
   assign last_capture = (state == FETCH) && capture && (cap_idx == LAST_WORD);

   assign BRAM_EN           = rd_en;
   assign BRAM_ADDR         = rd_en ? (BASE_ADDR + {5'd0, rd_idx}) : 8'h00;
   assign BUSY              = (state != IDLE);
   assign ERR               = err_pulse;
   assign SILENCER_SETTINGS = settings;

   // Control FSM: read issue, pending-request merge and back-to-back restart
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         pending <= 1'b0;
         rd_en   <= 1'b0;
         rd_idx  <= 3'd0;
      end else begin
         case (state)
            IDLE: begin
               if (REQ) begin
                  state  <= FETCH;
                  rd_en  <= 1'b1;
                  rd_idx <= 3'd0;
               end
            end
            FETCH: begin
               if (REQ) pending <= 1'b1;
               if (rd_en) begin
                  if (rd_idx == LAST_WORD) rd_en  <= 1'b0;
                  else                     rd_idx <= rd_idx + 3'd1;
               end
               if (last_capture) state <= CHECK;
            end
            CHECK: begin
               if (REQ) pending <= 1'b1;
               state <= COMMIT;
            end
            COMMIT: begin
               // A request arriving in this very cycle also restarts directly
               if (pending || REQ) begin
                  state   <= FETCH;
                  rd_en   <= 1'b1;
                  rd_idx  <= 3'd0;
                  pending <= 1'b0;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Capture shift register: follows each issued read until its data returns
   always_ff @(posedge CLK) begin
      if (RST) begin
         pipe_vld <= '0;
         for (int s = 0; s < RD_LATENCY; s++) pipe_idx[s] <= 3'd0;
      end else begin
         pipe_vld[0] <= rd_en;
         pipe_idx[0] <= rd_idx;
         for (int s = RD_LATENCY - 1; s > 0; s--) begin
            pipe_vld[s] <= pipe_vld[s-1];
            pipe_idx[s] <= pipe_idx[s-1];
         end
      end
   end

   // Shadow registers: returning words land here, never in the outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         sh_mode      <= 1'b0;
         sh_rate_int  <= 16'd0;
         sh_rate_phs  <= 16'd0;
         sh_steps_int <= 16'd0;
         sh_steps_phs <= 16'd0;
      end else if (capture) begin
         case (cap_idx)
            3'd0:    sh_mode      <= BRAM_DOUT[0];
            3'd1:    sh_rate_int  <= BRAM_DOUT;
            3'd2:    sh_rate_phs  <= BRAM_DOUT;
            3'd3:    sh_steps_int <= BRAM_DOUT;
            3'd4:    sh_steps_phs <= BRAM_DOUT;
            default: ;
         endcase
      end
   end

   // Validation: the fields that drive the selected mode must be non-zero
   always_comb begin
      cfg_ok = 1'b0;
      if (sh_mode) cfg_ok = (sh_steps_int != 16'd0) && (sh_steps_phs != 16'd0);
      else         cfg_ok = (sh_rate_int  != 16'd0) && (sh_rate_phs  != 16'd0);
   end

   // Publish on leaving CHECK so new fields and strobes are visible in COMMIT
   always_ff @(posedge CLK) begin
      if (RST) begin
         settings.UPDATE                     <= 1'b0;
         settings.MODE                       <= 1'b1;
         settings.UPDATE_RATE_INTENSITY      <= 16'd256;
         settings.UPDATE_RATE_PHASE          <= 16'd256;
         settings.COMPLETION_STEPS_INTENSITY <= 16'd10;
         settings.COMPLETION_STEPS_PHASE     <= 16'd40;
         err_pulse                           <= 1'b0;
      end else begin
         settings.UPDATE <= 1'b0;
         err_pulse       <= 1'b0;
         if (state == CHECK) begin
            if (cfg_ok) begin
               settings.UPDATE                     <= 1'b1;
               settings.MODE                       <= sh_mode;
               settings.UPDATE_RATE_INTENSITY      <= sh_rate_int;
               settings.UPDATE_RATE_PHASE          <= sh_rate_phs;
               settings.COMPLETION_STEPS_INTENSITY <= sh_steps_int;
               settings.COMPLETION_STEPS_PHASE     <= sh_steps_phs;
            end else begin
               err_pulse <= 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire
